// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM states, access-size encodings and opcodes for the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: Wishbone-style classic-cycle data bus between the LSU and data memory
interface load_store_unit_if;
  logic        bus_cyc;
  logic        bus_stb;
  logic        bus_we;
  logic [31:0] bus_adr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_dat_o;
  logic [31:0] bus_dat_i;
  logic        bus_ack;
  modport master (output bus_cyc, bus_stb, bus_we, bus_adr, bus_sel, bus_dat_o, input bus_dat_i, bus_ack);
  modport slave  (input bus_cyc, bus_stb, bus_we, bus_adr, bus_sel, bus_dat_o, output bus_dat_i, bus_ack);
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte-lane enables, store replication, load shift/mask and legality check
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] wdata,
  input  logic [31:0] dat_i,
  output logic [3:0]  sel,
  output logic [31:0] dat_o,
  output logic [31:0] rdata,
  output logic        legal
);
  logic [1:0]  sz;
  logic [31:0] shifted;
  assign sz      = funct3[1:0];
  assign sel     = sz == SZ_B ? 4'b0001 << off : sz == SZ_H ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
  assign dat_o   = sz == SZ_B ? {4{wdata[7:0]}} : sz == SZ_H ? {2{wdata[15:0]}} : wdata;
  assign shifted = dat_i >> {off, 3'b000};
  assign rdata   = shifted & (sz == SZ_B ? 32'h0000_00FF : sz == SZ_H ? 32'h0000_FFFF : 32'hFFFF_FFFF);
  assign legal   = !(rd && wr) && sz != 2'b11 && !(wr && funct3[2]) &&
                   !(sz == SZ_H && off[0]) && !(sz == SZ_W && off != 2'b00);
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: data-side bus initiator turning core load/store requests into classic bus cycles
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic        stall,
  output logic        done,
  output logic [31:0] read_data,
  output logic        misaligned,
  output logic        bus_err,
  load_store_unit_if.master bus
);
  state_t      state;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [31:0] cnt;
  logic [1:0]  lane_off;
  logic [2:0]  lane_f3;
  logic [3:0]  sel;
  logic [31:0] dat_o;
  logic [31:0] rdata;
  logic        legal;
  logic        req;
  logic        timeout;
  // outside IDLE the aligner works on the captured access, not the live inputs
  assign lane_off = state == IDLE ? addr[1:0] : off_q;
  assign lane_f3  = state == IDLE ? funct3 : f3_q;
  assign req      = mem_read | mem_write;
  assign timeout  = TIMEOUT_CYCLES != 0 && cnt == TIMEOUT_CYCLES - 1;
  assign stall    = (state == IDLE && req && legal) || state == REQ;
  lsu_lane_align u_align (
    .off    (lane_off),
    .funct3 (lane_f3),
    .rd     (mem_read),
    .wr     (mem_write),
    .wdata  (wdata),
    .dat_i  (bus.bus_dat_i),
    .sel    (sel),
    .dat_o  (dat_o),
    .rdata  (rdata),
    .legal  (legal)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      off_q         <= '0;
      f3_q          <= '0;
      cnt           <= '0;
      done          <= 1'b0;
      misaligned    <= 1'b0;
      bus_err       <= 1'b0;
      read_data     <= '0;
      bus.bus_cyc   <= 1'b0;
      bus.bus_stb   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_adr   <= '0;
      bus.bus_sel   <= '0;
      bus.bus_dat_o <= '0;
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (req && legal) begin
            state         <= REQ;
            off_q         <= addr[1:0];
            f3_q          <= funct3;
            cnt           <= '0;
            bus.bus_cyc   <= 1'b1;
            bus.bus_stb   <= 1'b1;
            bus.bus_we    <= mem_write;
            bus.bus_adr   <= {addr[31:2], 2'b00};
            bus.bus_sel   <= sel;
            bus.bus_dat_o <= dat_o;
          end else begin
            misaligned <= req;
          end
        end
        REQ: begin
          cnt <= cnt + 1;
          // ack takes priority over a timeout expiring in the same cycle
          if (bus.bus_ack || timeout) begin
            state       <= DONE;
            done        <= 1'b1;
            bus_err     <= !bus.bus_ack;
            bus.bus_cyc <= 1'b0;
            bus.bus_stb <= 1'b0;
            read_data   <= !bus.bus_ack ? 32'd0 : bus.bus_we ? read_data : rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random load/store transfers checked against a size/offset model
module tb_load_store_unit;
  localparam int TO = 4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [2:0]  funct3 = '0;
  logic        stall, done, misaligned, bus_err;
  logic [31:0] read_data;
  logic [31:0] exp_rd = '0;
  int          checks = 0;
  int          errors = 0;
  load_store_unit_if bus ();
  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .addr       (addr),
    .wdata      (wdata),
    .funct3     (funct3),
    .stall      (stall),
    .done       (done),
    .read_data  (read_data),
    .misaligned (misaligned),
    .bus_err    (bus_err),
    .bus        (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // waits = REQ cycles before the ack cycle; waits >= TO means no ack (timeout)
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, input int waits, input logic [31:0] dat);
    int          n;
    bit          legal;
    bit          acked;
    logic [3:0]  esel;
    logic [31:0] edat;
    n     = 1 << f3[1:0];
    legal = !(rd && wr) && f3[1:0] != 2'd3 && (a % n == 0) && !(wr && f3[2]);
    esel  = 4'(((1 << n) - 1) << a[1:0]);
    for (int i = 0; i < 4; i++) edat[8*i +: 8] = wd[8*(i % n) +: 8];
    @(negedge clk);
    chk("idle_pulses", {30'd0, done, misaligned}, 32'd0);
    mem_read = rd; mem_write = wr; addr = a; wdata = wd; funct3 = f3;
    #1 chk("stall_req", {31'd0, stall}, {31'd0, legal});
    @(negedge clk);
    if (!legal) begin
      chk("misaligned", {29'd0, bus.bus_cyc, stall, misaligned}, 32'd1);
      mem_read = 1'b0; mem_write = 1'b0;
      return;
    end
    acked = 1'b0;
    for (int k = 0; k < TO && !acked; k++) begin
      chk("req_ctl", {25'd0, bus.bus_cyc, bus.bus_stb, bus.bus_we, stall, done, misaligned, bus_err},
          {25'd0, 1'b1, 1'b1, wr, 1'b1, 1'b0, 1'b0, 1'b0});
      chk("req_adr", bus.bus_adr, {a[31:2], 2'b00});
      chk("req_sel", {28'd0, bus.bus_sel}, {28'd0, esel});
      if (wr) chk("req_dat", bus.bus_dat_o, edat);
      acked = (k == waits);
      bus.bus_ack = acked;
      bus.bus_dat_i = acked ? dat : $urandom;
      @(negedge clk);
      bus.bus_ack = 1'b0;
    end
    if (!acked) exp_rd = '0;
    else if (rd) exp_rd = (dat >> (8 * a[1:0])) & 32'((64'd1 << (8 * n)) - 1);
    chk("done", {28'd0, bus.bus_cyc, stall, done, bus_err}, {28'd0, 1'b0, 1'b0, 1'b1, !acked});
    chk("read_data", read_data, exp_rd);
  endtask
  initial begin
    bus.bus_ack = 1'b0;
    bus.bus_dat_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_outs", {26'd0, stall, done, misaligned, bus_err, bus.bus_cyc, bus.bus_stb}, 32'd0);
    chk("rst_bus", {bus.bus_adr | bus.bus_dat_o | read_data}, 32'd0);
    rst_n = 1'b1;
    access(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 0, 32'h0);
    access(1'b1, 1'b0, 32'h203, 32'h0, 3'b000, 3, 32'h80112233);
    chk("lb_value", read_data, 32'h00000080);
    access(1'b0, 1'b1, 32'h102, 32'h0000ABCD, 3'b001, 1, 32'h0);
    access(1'b1, 1'b0, 32'h101, 32'h0, 3'b010, 0, 32'h0);
    access(1'b1, 1'b0, 32'h40, 32'h0, 3'b010, TO, 32'h0);
    access(1'b1, 1'b0, 32'h44, 32'h0, 3'b010, TO - 1, 32'h12345678);
    access(1'b0, 1'b1, 32'h48, 32'h1, 3'b100, 0, 32'h0);
    access(1'b1, 1'b1, 32'h4C, 32'h1, 3'b010, 0, 32'h0);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    bus.bus_ack = 1'b1; bus.bus_dat_i = 32'hFFFFFFFF;
    @(negedge clk);
    bus.bus_ack = 1'b0;
    chk("stray_ack", {29'd0, done, stall, bus.bus_cyc}, 32'd0);
    chk("stray_ack_rd", read_data, exp_rd);
    @(negedge clk);
    mem_read = 1'b1; addr = 32'h300; funct3 = 3'b010;
    @(negedge clk);
    chk("pre_rst_cyc", {31'd0, bus.bus_cyc}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("rst_drop_cyc", {30'd0, bus.bus_cyc, bus.bus_stb}, 32'd0);
    mem_read = 1'b0;
    @(negedge clk);
    chk("rst_no_done", {29'd0, done, stall, bus_err}, 32'd0);
    rst_n = 1'b1;
    exp_rd = '0;
    access(1'b1, 1'b0, 32'h304, 32'h0, 3'b010, 1, 32'hCAFEF00D);
    for (int t = 0; t < 40; t++) begin
      int r;
      r = $urandom_range(0, 9);
      access(r < 5 || r == 9, r >= 5, $urandom, $urandom, 3'($urandom_range(0, 7)),
             $urandom_range(0, 5), $urandom);
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-side bus initiator for the single-cycle core: it takes the ALU's effective address, the rs2 store data and funct3 for load/store instructions, and turns them into Wishbone-style classic-cycle transfers to data memory. It returns lane-aligned load data to the register file write path and holds the core in stall while a transfer is outstanding. Misaligned accesses and bus timeouts are reported as single-cycle fault pulses.

## Interface
- TIMEOUT_CYCLES, 255, REQ cycles without bus_ack before abort; 0 disables timeout
- clk  in  1  core clock; all state changes on posedge
- rst_n  in  1  asynchronous, active-low reset
- mem_read  in  1  load instruction in execute (opcode 0000011)
- mem_write  in  1  store instruction in execute (opcode 0100011)
- addr  in  32  effective address (alu_output)
- wdata  in  32  store data (rs2_data)
- funct3  in  3  access size/sign: [1:0] size (00 B, 01 H, 10 W), [2] unsigned (loads only)
- stall  out  1  core must not advance PC or write registers
- done  out  1  one-cycle pulse: transfer complete, read_data valid
- read_data  out  32  load data right-justified, upper bits zero (register file extends)
- misaligned  out  1  one-cycle pulse: misaligned or illegal access, no bus cycle issued
- bus_err  out  1  one-cycle pulse, coincident with done, on timeout
- bus_cyc, bus_stb  out  1  bus cycle/strobe, asserted together
- bus_we  out  1  1 = write
- bus_adr  out  32  word address {addr[31:2],2'b00}
- bus_sel  out  4  byte lane enables
- bus_dat_o  out  32  write data, replicated across lanes
- bus_dat_i  in  32  read data
- bus_ack  in  1  transfer acknowledge

## Operation
- States: IDLE, REQ, DONE.
- IDLE: if (mem_read|mem_write) and access legal -> capture addr/wdata/funct3/we/sel into registers, stall=1 combinationally, next REQ. Illegal -> misaligned=1 registered pulse next cycle, stall=0, stay IDLE.
- Illegal: H with addr[0]=1; W with addr[1:0]!=0; funct3[1:0]=11; store with funct3[2]=1; mem_read and mem_write both high.
- REQ: bus_cyc=bus_stb=1, stall=1, timeout counter increments. bus_ack -> latch read_data (loads), next DONE. Counter reaches TIMEOUT_CYCLES -> drop bus, read_data=0, bus_err, next DONE.
- DONE: done=1, stall=0, request inputs ignored (same instruction still presented); next IDLE.
- Lanes: B sel=0001<<addr[1:0], dat_o={4{wdata[7:0]}}; H sel=0011<<{addr[1],0}, dat_o={2{wdata[15:0]}}; W sel=1111, dat_o=wdata.
- Load: read_data = (bus_dat_i >> 8*addr[1:0]) masked to 8/16/32 bits.
- bus_ack outside REQ ignored.
- read_data holds until next acknowledged load or timeout.

## Timing
- Reset: state IDLE, all outputs 0, counter 0; mid-transfer reset drops bus_cyc/bus_stb immediately (async), no done pulse.
- Bus outputs registered: bus_cyc rises one cycle after request seen in IDLE.
- Minimum latency: request cycle N (stall=1), REQ with ack cycle N+1, DONE cycle N+2 (done=1, stall=0); core advances at end of N+2.
- Each extra wait state adds one cycle; timeout abort after exactly TIMEOUT_CYCLES REQ cycles.
- Ack arriving in the same cycle as timeout expiry: ack wins, no bus_err.
- bus_adr/sel/we/dat_o stable for the whole REQ phase.

## Structure
- lsu_pkg: state enum, size encodings (SZ_B/SZ_H/SZ_W), LOAD/STORE opcode constants.
- Sub-module lsu_lane_align: combinational sel/dat_o generation, load shift/mask, legality check.
- Top: FSM, capture registers, timeout counter.

## Test plan
- SW addr 0x100, wdata 0xDEADBEEF, ack after 1 cycle -> bus_adr 0x100, sel 1111, we=1, done at N+2, stall high N..N+1.
- LB addr 0x203, bus_dat_i 0x80112233, ack after 3 waits -> sel 1000, read_data 0x00000080, done at N+5.
- SH addr 0x102, wdata 0x0000ABCD -> sel 1100, bus_dat_o 0xABCDABCD.
- LW addr 0x101 -> misaligned pulse at N+1, no bus_cyc, stall never high.
- TIMEOUT_CYCLES=4, LW without ack -> bus_cyc 4 cycles, then done+bus_err, read_data 0; ack on 4th cycle instead -> no bus_err.
- rst_n low during REQ -> bus_cyc 0 immediately, state IDLE, no done; next LW completes normally.
